// File: rtl/ma_decimator_pkg.sv
// Shared constants for the moving-average decimator: bus widths, register
// map, reset defaults and small helpers for the window length.
package ma_decimator_pkg;

    localparam int unsigned BITS_ADC       = 8;
    localparam int unsigned MA_ACUM_WIDTH  = 16;
    localparam int unsigned MAX_N          = MA_ACUM_WIDTH - BITS_ADC;
    localparam int unsigned ADC_DF_WIDTH   = 32;
    localparam int unsigned REG_ADDR_WIDTH = 8;
    localparam int unsigned REG_DATA_WIDTH = 16;
    localparam int unsigned N_WIDTH        = 4;
    // Sample counter only needs to reach 2^MAX_N - 1.
    localparam int unsigned CNT_WIDTH      = MAX_N;

    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_N_MOVING_AVERAGE = 8'h05;
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_DF_L             = 8'h01;
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_DF_H             = 8'h02;

    localparam logic [N_WIDTH-1:0]      DEFAULT_N_MOVING_AVERAGE = '0;
    localparam logic [ADC_DF_WIDTH-1:0] DEFAULT_DF               = '0;

    // Effective averaging exponent; larger values would overflow the accumulator.
    function automatic logic [N_WIDTH-1:0] clamp_n(input logic [N_WIDTH-1:0] n);
        return (n > N_WIDTH'(MAX_N)) ? N_WIDTH'(MAX_N) : n;
    endfunction

    // Counter value of the last sample in a 2^n window.
    function automatic logic [CNT_WIDTH-1:0] window_last(input logic [N_WIDTH-1:0] n);
        logic [CNT_WIDTH:0] len;
        len = (CNT_WIDTH+1)'(1) << n;
        return CNT_WIDTH'(len - (CNT_WIDTH+1)'(1));
    endfunction

endpackage

// File: rtl/ma_decimator_if.sv
// Registers bus shared by the configuration blocks.
//   register_addr : write address
//   register_data : write data
//   register_rdy  : one-cycle write strobe
interface ma_decimator_if;
    import ma_decimator_pkg::*;

    logic [REG_ADDR_WIDTH-1:0] register_addr;
    logic [REG_DATA_WIDTH-1:0] register_data;
    logic                      register_rdy;

    modport master (output register_addr, output register_data, output register_rdy);
    modport slave  (input  register_addr, input  register_data, input  register_rdy);
endinterface

// File: rtl/ma_decimator_sample_decimator.sv
// Keeps one of every df+1 input strobes, starting with the first after clear.
//   clk, rst : clock, async active-high reset
//   clear    : synchronous clear; also drops an input strobe of the same cycle
//   df       : decimation factor (number of strobes skipped after each kept one)
//   in_data/in_rdy   : input sample and strobe
//   out_data/out_rdy : kept sample (held between strobes) and one-cycle strobe
module sample_decimator #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DF_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DF_WIDTH-1:0]   df,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_rdy
);

    logic [DF_WIDTH-1:0] dcnt;

    // Decimation counter wraps on equality so df = all-ones is legal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt     <= '0;
            out_data <= '0;
            out_rdy  <= 1'b0;
        end else begin
            out_rdy <= 1'b0;
            if (clear) begin
                dcnt <= '0;
            end else if (in_rdy) begin
                if (dcnt == '0) begin
                    out_data <= in_data;
                    out_rdy  <= 1'b1;
                end
                dcnt <= (dcnt == df) ? '0 : dcnt + DF_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/ma_decimator.sv
// Per-channel ADC conditioning: block-average 2^n samples, then decimate by df+1.
//   clk, rst   : clock, async active-high reset
//   restart    : one-cycle pulse clearing accumulator and counters
//   adc_data_i/adc_rdy_i : raw sample and its strobe
//   reg_bus    : registers bus (N, DF_L, DF_H); writes to these also clear
//   data_o/rdy_o : processed sample (held) and one-cycle strobe
module ma_decimator
    import ma_decimator_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                restart,
    input  logic [BITS_ADC-1:0] adc_data_i,
    input  logic                adc_rdy_i,
    ma_decimator_if.slave       reg_bus,
    output logic [BITS_ADC-1:0] data_o,
    output logic                rdy_o
);

    logic [N_WIDTH-1:0]       n_reg;
    logic [ADC_DF_WIDTH-1:0]  df_reg;
    logic [MA_ACUM_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0]     cnt;
    logic [BITS_ADC-1:0]      avg;
    logic                     avg_rdy;

    logic                     hit_n_c, hit_dfl_c, hit_dfh_c, clear_c;
    logic [N_WIDTH-1:0]       n_eff_c;
    logic [CNT_WIDTH-1:0]     last_c;
    logic [MA_ACUM_WIDTH-1:0] sum_c;
    logic [BITS_ADC-1:0]      avg_c;

    // Register decode, clear generation and window arithmetic.
    always_comb begin
        hit_n_c   = reg_bus.register_rdy && (reg_bus.register_addr == ADDR_N_MOVING_AVERAGE);
        hit_dfl_c = reg_bus.register_rdy && (reg_bus.register_addr == ADDR_DF_L);
        hit_dfh_c = reg_bus.register_rdy && (reg_bus.register_addr == ADDR_DF_H);
        clear_c   = restart || hit_n_c || hit_dfl_c || hit_dfh_c;
        n_eff_c   = clamp_n(n_reg);
        last_c    = window_last(n_eff_c);
        sum_c     = acc + MA_ACUM_WIDTH'(adc_data_i);
        avg_c     = BITS_ADC'(sum_c >> n_eff_c);
    end

    // Configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_reg  <= DEFAULT_N_MOVING_AVERAGE;
            df_reg <= DEFAULT_DF;
        end else begin
            if (hit_n_c)   n_reg         <= reg_bus.register_data[N_WIDTH-1:0];
            if (hit_dfl_c) df_reg[15:0]  <= reg_bus.register_data;
            if (hit_dfh_c) df_reg[31:16] <= reg_bus.register_data;
        end
    end

    // Stage 1: accumulate-and-dump; a clear discards the sample of the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            avg     <= '0;
            avg_rdy <= 1'b0;
        end else begin
            avg_rdy <= 1'b0;
            if (clear_c) begin
                acc <= '0;
                cnt <= '0;
            end else if (adc_rdy_i) begin
                if (cnt == last_c) begin
                    avg     <= avg_c;
                    avg_rdy <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= sum_c;
                    cnt <= cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Stage 2: decimation.
    sample_decimator #(
        .DATA_WIDTH (BITS_ADC),
        .DF_WIDTH   (ADC_DF_WIDTH)
    ) u_dec (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_c),
        .df       (df_reg),
        .in_data  (avg),
        .in_rdy   (avg_rdy),
        .out_data (data_o),
        .out_rdy  (rdy_o)
    );

endmodule

// File: tb/tb_ma_decimator.sv
// Bench for ma_decimator: table of configured windows, hand-written corner
// sequences and random traffic, all checked against a queue-based model.
module tb_ma_decimator;
    import ma_decimator_pkg::*;

    logic       clk, rst, restart, adc_rdy_i, rdy_o;
    logic [7:0] adc_data_i, data_o;
    ma_decimator_if bus();

    ma_decimator dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .adc_data_i (adc_data_i),
        .adc_rdy_i  (adc_rdy_i),
        .reg_bus    (bus.slave),
        .data_o     (data_o),
        .rdy_o      (rdy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int out_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int due; logic [7:0] val; } exp_t;
    exp_t        expq[$];
    logic [7:0]  win[$];
    logic [3:0]  m_n;
    logic [31:0] m_df;
    longint      m_idx;
    logic [7:0]  last_val;

    task automatic model_reset();
        expq.delete();
        win.delete();
        m_n = 4'd0;
        m_df = 32'd0;
        m_idx = 0;
        last_val = 8'd0;
    endtask

    // Called at the negedge before the posedge that samples these inputs.
    task automatic model_step(input logic a, input logic [7:0] d, input logic rs,
                              input logic rr, input logic [7:0] ad, input logic [15:0] wd);
        logic clr;
        int   n, sum, avg;
        clr = rs || (rr && (ad == 8'h05 || ad == 8'h01 || ad == 8'h02));
        if (clr) begin
            win.delete();
            m_idx = 0;
            // an average produced at the previous edge would emerge next cycle: dropped
            while (expq.size() > 0 && expq[expq.size()-1].due == cyc + 1)
                void'(expq.pop_back());
        end else if (a) begin
            win.push_back(d);
            n = (m_n > 4'd8) ? 8 : int'(m_n);
            if (win.size() == (1 << n)) begin
                sum = 0;
                foreach (win[i]) sum += int'(win[i]);
                avg = sum / (1 << n);
                if (m_idx % (longint'(m_df) + 1) == 0)
                    expq.push_back('{cyc + 2, 8'(avg)});
                m_idx++;
                win.delete();
            end
        end
        if (rr) begin
            if (ad == 8'h05) m_n = wd[3:0];
            if (ad == 8'h01) m_df[15:0] = wd;
            if (ad == 8'h02) m_df[31:16] = wd;
        end
    endtask

    // Every cycle: strobe timing and held/updated data against the model.
    always @(negedge clk) begin
        if (!rst) begin
            logic er;
            er = (expq.size() > 0 && expq[0].due == cyc);
            chk("rdy_o", 32'(rdy_o), 32'(er));
            if (er) begin
                last_val = expq[0].val;
                void'(expq.pop_front());
            end
            if (rdy_o) out_cnt++;
            chk("data_o", 32'(data_o), 32'(last_val));
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic a, input logic [7:0] d, input logic rs,
                         input logic rr, input logic [7:0] ad, input logic [15:0] wd);
        @(negedge clk);
        adc_rdy_i = a; adc_data_i = d; restart = rs;
        bus.register_rdy = rr; bus.register_addr = ad; bus.register_data = wd;
        model_step(a, d, rs, rr, ad, wd);
    endtask

    task automatic smp(input logic [7:0] d);   drive(1'b1, d, 1'b0, 1'b0, 8'h00, 16'h0); endtask
    task automatic wr(input logic [7:0] ad, input logic [15:0] wd); drive(1'b0, 8'h00, 1'b0, 1'b1, ad, wd); endtask
    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0);
    endtask
    task automatic config_all(input logic [3:0] n, input logic [31:0] df);
        wr(8'h05, 16'(n)); wr(8'h01, df[15:0]); wr(8'h02, df[31:16]);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  n;
        logic [31:0] df;
        int          nsamp;
        logic [7:0]  base;
        logic [7:0]  step;
        int          exp_outs;
        logic [7:0]  exp_last;
    } vec_t;
    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'd0,  32'd0, 3,   8'd10,  8'd10, 3, 8'd30};
        vecs[1] = '{4'd2,  32'd0, 4,   8'd4,   8'd4,  1, 8'd10};
        vecs[2] = '{4'd2,  32'd0, 4,   8'd255, 8'd0,  1, 8'd255};
        vecs[3] = '{4'd15, 32'd0, 256, 8'd255, 8'd0,  1, 8'd255};
        vecs[4] = '{4'd0,  32'd2, 9,   8'd0,   8'd1,  3, 8'd6};
        vecs[5] = '{4'd1,  32'd1, 8,   8'd1,   8'd2,  2, 8'd10};
        vecs[6] = '{4'd3,  32'd0, 8,   8'd0,   8'd3,  1, 8'd10};
        vecs[7] = '{4'd9,  32'd0, 256, 8'd0,   8'd1,  1, 8'd127};

        model_reset();
        rst = 1'b1; restart = 1'b0; adc_rdy_i = 1'b0; adc_data_i = 8'h00;
        bus.register_rdy = 1'b0; bus.register_addr = 8'h00; bus.register_data = 16'h0;
        #2;
        chk("reset_data", 32'(data_o), 32'd0);
        chk("reset_rdy", 32'(rdy_o), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // defaults: pass-through, two-cycle latency
        out_cnt = 0;
        smp(8'd10); smp(8'd20); smp(8'd30);
        idle(4);
        chk("default_outs", 32'(out_cnt), 32'd3);
        chk("default_last", 32'(data_o), 32'd30);

        foreach (vecs[v]) begin
            config_all(vecs[v].n, vecs[v].df);
            out_cnt = 0;
            for (int i = 0; i < vecs[v].nsamp; i++)
                smp(8'(int'(vecs[v].base) + int'(vecs[v].step) * i));
            idle(4);
            chk($sformatf("vec%0d_outs", v), 32'(out_cnt), 32'(vecs[v].exp_outs));
            chk($sformatf("vec%0d_last", v), 32'(data_o), 32'(vecs[v].exp_last));
        end

        // truncating average of a non-multiple sum
        config_all(4'd2, 32'd0);
        out_cnt = 0;
        smp(8'd4); smp(8'd8); smp(8'd12); smp(8'd17);
        idle(4);
        chk("trunc_outs", 32'(out_cnt), 32'd1);
        chk("trunc_val", 32'(data_o), 32'd10);

        // restart coinciding with the window-completing sample
        out_cnt = 0;
        smp(8'd1); smp(8'd2); smp(8'd3);
        drive(1'b1, 8'd9, 1'b1, 1'b0, 8'h00, 16'h0);
        idle(4);
        chk("collide_none", 32'(out_cnt), 32'd0);
        smp(8'd1); smp(8'd1); smp(8'd1); smp(8'd1);
        idle(4);
        chk("collide_next", 32'(out_cnt), 32'd1);
        chk("collide_val", 32'(data_o), 32'd1);

        // clearing write kills an in-flight average; foreign address does not
        config_all(4'd0, 32'd0);
        out_cnt = 0;
        smp(8'd50); wr(8'h01, 16'h0000);
        idle(4);
        chk("inflight_drop", 32'(out_cnt), 32'd0);
        smp(8'd60); wr(8'h07, 16'h1234);
        idle(4);
        chk("foreign_addr", 32'(out_cnt), 32'd1);
        chk("foreign_val", 32'(data_o), 32'd60);

        // maximum DF: only the first sample after a clear is emitted
        config_all(4'd0, 32'hFFFF_FFFF);
        out_cnt = 0;
        for (int i = 1; i <= 5; i++) smp(8'(i));
        idle(4);
        chk("dfmax_outs", 32'(out_cnt), 32'd1);
        chk("dfmax_val", 32'(data_o), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0);
        smp(8'd9);
        idle(4);
        chk("dfmax_restart", 32'(out_cnt), 32'd2);
        chk("dfmax_rval", 32'(data_o), 32'd9);

        // async reset mid-window
        config_all(4'd3, 32'd0);
        for (int i = 0; i < 5; i++) smp(8'd40);
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_data", 32'(data_o), 32'd0);
        chk("arst_rdy", 32'(rdy_o), 32'd0);
        #1 rst = 1'b0;
        out_cnt = 0;
        smp(8'd77);
        idle(4);
        chk("arst_pass", 32'(out_cnt), 32'd1);
        chk("arst_val", 32'(data_o), 32'd77);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            logic       a, rs, rr;
            logic [7:0] ad;
            logic [15:0] wd;
            a  = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 149) == 0);
            rr = ($urandom_range(0, 199) == 0);
            ad = 8'h00; wd = 16'h0;
            if (rr) begin
                case ($urandom_range(0, 4))
                    0: begin ad = 8'h05; wd = 16'($urandom_range(0, 10)); end
                    1: begin ad = 8'h01; wd = 16'($urandom_range(0, 3)); end
                    2: begin ad = 8'h02; wd = 16'h0; end
                    3: begin ad = 8'h07; wd = 16'($urandom); end
                    default: begin ad = 8'h15; wd = 16'($urandom); end
                endcase
            end
            drive(a, 8'($urandom), rs, rr, ad, wd);
        end
        idle(4);
        chk("pending_empty", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
